// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundles for the fetch stage: instruction-memory port and decode port.
interface imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

interface dec_if;
    import fetch_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] Instr;
    logic [31:0]        instr_pc;
    logic [31:0]        PCPlus8;

    modport master (output instr_valid, Instr, instr_pc, PCPlus8, input instr_ready);
    modport slave  (input instr_valid, Instr, instr_pc, PCPlus8, output instr_ready);
endinterface

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush; push and pop may
// coincide at any fill level.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory reads, instruction
// buffer and branch redirect handling.
//
//   state | meaning
//   FETCH | request outstanding at fetch_pc; ack pushes word, pc += 4
//   HOLD  | buffer full, no request until a slot frees
//   DRAIN | stale request in flight after redirect; discard it, then go to target
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    imem_if.master      imem,
    dec_if.master       dec,
    input  logic        PCSrc,
    input  logic [31:0] branch_target
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]   target;
    logic          req;
    logic          push;
    logic          pop;
    logic          valid;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  wentry;

    assign target = word_align(branch_target);
    assign valid  = (count != '0);
    assign pop    = valid && dec.instr_ready;
    assign wentry = '{pc: fetch_pc_q, instr: imem.imem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= word_align(RESET_PC);
            redirect_pc_q <= word_align(RESET_PC);
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        req           = 1'b0;
        push          = 1'b0;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (PCSrc) begin
                    if (imem.imem_ack) begin
                        fetch_pc_d = target;
                    end else begin
                        redirect_pc_d = target;
                        state_d       = DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    // Stop requesting once this push fills the buffer.
                    if (count + CW'(1) - CW'(pop) == CW'(DEPTH)) state_d = HOLD;
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    fetch_pc_d = target;
                    state_d    = FETCH;
                end else if (count < CW'(DEPTH)) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                req = 1'b1;
                if (PCSrc) redirect_pc_d = target;
                if (imem.imem_ack) begin
                    fetch_pc_d = PCSrc ? target : redirect_pc_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (PCSrc),
        .wdata (wentry),
        .rdata (head),
        .count (count)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;

    assign dec.instr_valid = valid;
    assign dec.Instr       = valid ? head.instr : '0;
    assign dec.instr_pc    = valid ? head.pc : 32'h0;
    assign dec.PCPlus8     = dec.instr_pc + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [31:0] branch_target;
    int          lat  = 0;
    logic [31:0] xorv = 32'h0;
    int          wcnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imem_if mem_bus ();
    dec_if  dec_bus ();

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (mem_bus),
        .dec           (dec_bus),
        .PCSrc         (PCSrc),
        .branch_target (branch_target)
    );

    // Memory answers lat cycles after the request starts; data = addr ^ xorv.
    always @(posedge clk) begin
        if (reset || !mem_bus.imem_req || mem_bus.imem_ack) wcnt <= 0;
        else                                                 wcnt <= wcnt + 1;
    end
    assign mem_bus.imem_ack   = mem_bus.imem_req && (wcnt == lat);
    assign mem_bus.imem_rdata = mem_bus.imem_ack ? (mem_bus.imem_addr ^ xorv) : 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Returns at the negedge after the reset edge with reset already released.
    task automatic reset_dut(input int l, input logic [31:0] x);
        @(negedge clk);
        reset = 1'b1;
        PCSrc = 1'b0;
        lat   = l;
        xorv  = x;
        dec_bus.instr_ready = 1'b1;
        @(negedge clk);
        check("rst_req",   {31'h0, mem_bus.imem_req},    32'h1);
        check("rst_addr",  mem_bus.imem_addr,            32'h0);
        check("rst_valid", {31'h0, dec_bus.instr_valid}, 32'h0);
        check("rst_instr", dec_bus.Instr,                32'h0);
        check("rst_pc",    dec_bus.instr_pc,             32'h0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        PCSrc = 1'b0;
        branch_target = 32'h0;
        dec_bus.instr_ready = 1'b1;

        // Zero-wait memory, full throughput.
        reset_dut(0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_valid", {31'h0, dec_bus.instr_valid}, 32'h1);
            check("t1_pc",    dec_bus.instr_pc, 32'(4 * k));
            check("t1_pc8",   dec_bus.PCPlus8,  32'(4 * k + 8));
            check("t1_instr", dec_bus.Instr,    32'(4 * k));
        end

        // Three-cycle memory latency: address held, one instruction per 4 cycles.
        reset_dut(3, 32'hA5A5_0000);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) step();
            check("t2_req",  {31'h0, mem_bus.imem_req}, 32'h1);
            check("t2_addr", mem_bus.imem_addr, 32'(4 * ((c - 1) / 4)));
            if (c >= 5 && (c % 4) == 1) begin
                check("t2_valid", {31'h0, dec_bus.instr_valid}, 32'h1);
                check("t2_pc",    dec_bus.instr_pc, 32'(4 * ((c - 5) / 4)));
                check("t2_instr", dec_bus.Instr, 32'(4 * ((c - 5) / 4)) ^ 32'hA5A5_0000);
            end else begin
                check("t2_idle", {31'h0, dec_bus.instr_valid}, 32'h0);
            end
        end

        // Decode stalled: buffer fills to DEPTH, requests stop, then resume at 8.
        reset_dut(0, 32'h0);
        dec_bus.instr_ready = 1'b0;
        repeat (10) step();
        check("t3_hold_req", {31'h0, mem_bus.imem_req},    32'h0);
        check("t3_valid0",   {31'h0, dec_bus.instr_valid}, 32'h1);
        check("t3_pc0",      dec_bus.instr_pc, 32'h0);
        dec_bus.instr_ready = 1'b1;
        step();
        check("t3_pc4",      dec_bus.instr_pc, 32'h4);
        check("t3_req_off",  {31'h0, mem_bus.imem_req}, 32'h0);
        step();
        check("t3_req_on",   {31'h0, mem_bus.imem_req}, 32'h1);
        check("t3_addr8",    mem_bus.imem_addr, 32'h8);
        check("t3_bubble",   {31'h0, dec_bus.instr_valid}, 32'h0);
        step();
        check("t3_pc8",      dec_bus.instr_pc, 32'h8);

        // Redirect while the request to 8 is still waiting.
        reset_dut(3, 32'h1234_0000);
        repeat (8) step();
        check("t4_pc4", dec_bus.instr_pc, 32'h4);
        dec_bus.instr_ready = 1'b0;
        step();
        check("t4_held",  dec_bus.instr_pc, 32'h4);
        check("t4_addr8", mem_bus.imem_addr, 32'h8);
        PCSrc = 1'b1;
        branch_target = 32'h100;
        step();
        PCSrc = 1'b0;
        check("t4_flush",  {31'h0, dec_bus.instr_valid}, 32'h0);
        check("t4_drain",  mem_bus.imem_addr, 32'h8);
        check("t4_dreq",   {31'h0, mem_bus.imem_req}, 32'h1);
        dec_bus.instr_ready = 1'b1;
        step();
        check("t4_drain2", mem_bus.imem_addr, 32'h8);
        for (int c = 13; c <= 16; c++) begin
            step();
            check("t4_taddr", mem_bus.imem_addr, 32'h100);
            check("t4_nov",   {31'h0, dec_bus.instr_valid}, 32'h0);
        end
        step();
        check("t4_tvalid", {31'h0, dec_bus.instr_valid}, 32'h1);
        check("t4_tpc",    dec_bus.instr_pc, 32'h100);
        check("t4_tinstr", dec_bus.Instr, 32'h100 ^ 32'h1234_0000);

        // Redirect coinciding with an ack; unaligned target.
        reset_dut(0, 32'h0);
        step();
        check("t5_addr4", mem_bus.imem_addr, 32'h4);
        check("t5_pc0",   dec_bus.instr_pc, 32'h0);
        PCSrc = 1'b1;
        branch_target = 32'h203;
        step();
        PCSrc = 1'b0;
        check("t5_addr", mem_bus.imem_addr, 32'h200);
        check("t5_nov",  {31'h0, dec_bus.instr_valid}, 32'h0);
        step();
        check("t5_pc",    dec_bus.instr_pc, 32'h200);
        check("t5_instr", dec_bus.Instr, 32'h200);

        // Ack arriving in a reset cycle is dropped.
        reset_dut(0, 32'h0);
        step();
        reset = 1'b1;
        step();
        check("t6_rvalid", {31'h0, dec_bus.instr_valid}, 32'h0);
        check("t6_raddr",  mem_bus.imem_addr, 32'h0);
        reset = 1'b0;
        step();
        check("t6_pc", dec_bus.instr_pc, 32'h0);

        // Reset with the buffer full.
        reset_dut(3, 32'h0);
        dec_bus.instr_ready = 1'b0;
        repeat (9) step();
        check("t6_full_req", {31'h0, mem_bus.imem_req},    32'h0);
        check("t6_full_v",   {31'h0, dec_bus.instr_valid}, 32'h1);
        reset = 1'b1;
        step();
        check("t6_clr_req",   {31'h0, mem_bus.imem_req},    32'h1);
        check("t6_clr_addr",  mem_bus.imem_addr,            32'h0);
        check("t6_clr_valid", {31'h0, dec_bus.instr_valid}, 32'h0);
        check("t6_clr_instr", dec_bus.Instr,                32'h0);
        reset = 1'b0;
        dec_bus.instr_ready = 1'b1;

        // PC wrap from 0xFFFF_FFFC.
        reset_dut(0, 32'h0);
        step();
        PCSrc = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        PCSrc = 1'b0;
        check("t7_addr", mem_bus.imem_addr, 32'hFFFF_FFFC);
        step();
        check("t7_wrap", mem_bus.imem_addr, 32'h0);
        check("t7_pc",   dec_bus.instr_pc, 32'hFFFF_FFFC);
        check("t7_pc8",  dec_bus.PCPlus8,  32'h4);
        step();
        check("t7_pc0",  dec_bus.instr_pc, 32'h0);
        check("t7_a4",   mem_bus.imem_addr, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction decoder.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents them with their PC to decode under a valid/ready handshake.
- Applies taken-branch / PC-write redirects (PCSrc from conditional logic) by flushing the buffer and refetching from the target.

Parameters:
- DEPTH, 2, instruction buffer entries (power of two, >= 2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned read address; bits [1:0] always 0.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  instruction word, valid only when imem_ack=1.
- PCSrc  in  1  redirect request, one-cycle pulse.
- branch_target  in  32  redirect address, sampled when PCSrc=1; bits [1:0] ignored and forced to 0.
- instr_valid  out  1  Instr / instr_pc hold a valid instruction.
- instr_ready  in  1  decode accepts the head instruction this cycle.
- Instr  out  32  head instruction; 32'h0 when instr_valid=0.
- instr_pc  out  32  address of Instr; 32'h0 when instr_valid=0.
- PCPlus8  out  32  instr_pc+8 (ARM PC-read value), modulo 2^32.

Behaviour:
- Reset (any cycle, including mid-transaction):
  - fetch_pc=RESET_PC, FIFO emptied, state=FETCH.
  - Outputs in the reset cycle's following cycle: imem_req=1, instr_valid=0, Instr=0, instr_pc=0.
  - Any ack arriving in the reset cycle is dropped.
- Memory handshake:
  - One outstanding request maximum.
  - Once imem_req=1, imem_req and imem_addr stay stable until the cycle imem_ack=1.
  - Zero-wait ack (same cycle as the request) is legal.
  - imem_ack while imem_req=0 is ignored.
- States:
  - FETCH: imem_req=1, imem_addr=fetch_pc.
    - On ack: push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps mod 2^32).
    - After the ack, go to HOLD if FIFO count after push/pop equals DEPTH; otherwise stay in FETCH and issue the next request on the following cycle.
  - HOLD: imem_req=0. Go to FETCH when count < DEPTH.
  - DRAIN: imem_req=1 with the stale address. On ack, discard the data, set fetch_pc=redirect_pc, go to FETCH.
- Redirect (PCSrc=1): highest priority after reset.
  - FIFO flushed in the same edge; a pop in that cycle is discarded.
  - FETCH without ack in the same cycle: save redirect_pc=target, go to DRAIN.
  - FETCH with ack in the same cycle: drop the data, fetch_pc=target, stay in FETCH.
  - HOLD: fetch_pc=target, go to FETCH.
  - DRAIN: overwrite redirect_pc with the newest target.
  - instr_valid=0 from the next cycle until the first target word is pushed.
- FIFO:
  - Push and pop in the same cycle are legal at any count, including full.
  - instr_valid = count != 0.
  - Latency: ack at cycle n -> instr_valid at n+1 if the FIFO was empty. No combinational path from imem_* to instr_* outputs.
  - Throughput: one instruction per cycle with zero-wait memory and instr_ready held high.

Decomposition:
- Package fetch_pkg:
  - typedef enum fetch_state_t {FETCH, HOLD, DRAIN}.
  - Constants INSTR_W=32, PC_STEP=4.
  - typedef struct fetch_entry_t {pc, instr}.
- Sub-module instr_fifo:
  - Parameterised synchronous FIFO of fetch_entry_t with push/pop/flush and count.
  - Same clk/reset.

Test Plan:
- Reset, zero-wait memory returning addr as data, instr_ready=1 -> instr_pc sequence 0,4,8,12 on consecutive cycles; PCPlus8 = 8,12,16,20.
- Memory acks 3 cycles after req -> imem_addr stable during the wait; one instruction every 4 cycles; Instr matches rdata.
- instr_ready=0 for 10 cycles -> exactly DEPTH=2 words buffered, then imem_req=0; instr_ready=1 -> words 0,4 emerge in order and fetching resumes at 8.
- PCSrc=1, target=32'h100, while a request to 8 waits 2 more cycles -> addr 8 held until ack, its data is never presented, next request is 32'h100, first valid instr_pc=32'h100.
- PCSrc=1, target=32'h203, in the same cycle as an ack for 4 -> data for 4 dropped, next imem_addr=32'h200.
- reset asserted mid-wait with FIFO full, and fetch_pc=32'hFFFF_FFFC ack run -> reset clears to RESET_PC; wrap case: next address is 32'h0.
